lcd_char_writer: RTL and testbench
==================================

// Module: lcd_char_writer
// PURPOSE
//   HD44780 write-side controller for the DE2 16x2 LCD; the responder to client logic that presents data/selectCD/enableWriting.
//   After reset it runs the power-up init sequence, then accepts one request per handshake.
//   A request is either 4 packed ASCII characters or one command byte.
//   It drives the 8-bit LCD bus with correct EN timing and reports LCD_Available when it can take a new request.
// PARAMETERS
//   EN_PULSE_CYC   14      EN high time in clocks (>=450 ns @27 MHz)
//   CMD_WAIT_CYC   1080    post-byte wait, normal cmd/data (40 us)
//   CLR_WAIT_CYC   44280   post-byte wait after 0x01/0x02 (1.64 ms)
//   PWRUP_WAIT_CYC 405000  wait after reset before first init byte (15 ms)
// PORTS
//   CLOCK_27       in    1   system clock, 27 MHz
//   rst            in    1   reset, asynchronous, active-high
//   data           in    32  selectCD=1: 4 chars, [31:24] sent first; selectCD=0: command in [7:0]
//   selectCD       in    1   1 = character data (RS=1), 0 = command (RS=0)
//   enableWriting  in    1   request strobe, level-sampled while LCD_Available=1
//   LCD_Available  out   1   1 = idle, next enableWriting accepted
//   LCD_DATA       inout 8   LCD bus; always driven (write-only, never tri-stated)
//   LCD_RW         out   1   constant 0
//   LCD_RS         out   1   register select for current byte
//   LCD_EN         out   1   enable strobe
//   LCD_ON         out   1   constant 1 (panel power)
//   LCD_BLON       out   1   constant 1 (backlight)
// BEHAVIOUR
//   Reset values:
//     - LCD_Available=0, LCD_EN=0, LCD_RS=0, LCD_DATA=8'h00, LCD_RW=0, LCD_ON=1, LCD_BLON=1.
//     - FSM=PWRUP, wait counter=0.
//   FSM states:
//     - PWRUP: wait PWRUP_WAIT_CYC -> INIT.
//     - INIT: send 38,38,38,0C,01,06 (RS=0), each with its post-wait -> IDLE.
//     - IDLE: LCD_Available=1.
//     - LOAD: latch data/selectCD; LCD_Available=0.
//     - SEND: per-byte sequence below.
//     - NEXT: advance byte index; after last byte -> IDLE.
//   Per byte, driven by lcd_byte_sender:
//     - SETUP: 1 clk, RS and DATA stable, EN=0.
//     - PULSE: EN=1 for EN_PULSE_CYC clks.
//     - HOLD: EN=0, DATA/RS held for the post-wait.
//   Post-wait selection:
//     - CLR_WAIT_CYC if RS=0 and byte is 8'h01 or 8'h02.
//     - CMD_WAIT_CYC otherwise.
//   Handshake:
//     - enableWriting=1 in IDLE at clk edge N: LCD_Available=0 from N+1; first EN rise at N+2.
//     - enableWriting held high: a new transaction starts on every return to IDLE. Level, not edge.
//     - Requests while LCD_Available=0 are ignored, not queued.
//     - data/selectCD may change after the accept edge; the latched copy is used.
//   Character mode:
//     - Bytes go out [31:24],[23:16],[15:8],[7:0].
//     - A byte equal to 8'h00 is skipped: no EN pulse, no wait.
//     - All four bytes 0: IDLE is re-entered 2 clks after accept with no bus activity.
//   Command mode: exactly one byte, data[7:0], RS=0. Upper 24 bits are ignored.
//   DDRAM cursor: not tracked here; the client positions it with 8'h80|addr commands.
//   Reset mid-operation: outputs go to reset values at once (EN drops asynchronously); the full PWRUP+INIT repeats.
//   Counter width: $clog2(PWRUP_WAIT_CYC+1). Must hold the largest of all wait parameters.
// STRUCTURE
//   lcd_defs.vh (shared include):
//     - Command constants: CMD_FUNCSET_8B2L=8'h38, CMD_DISP_ON=8'h0C, CMD_CLEAR=8'h01,
//       CMD_HOME=8'h02, CMD_ENTRY_INC=8'h06, CMD_SET_DDRAM=8'h80.
//     - Top FSM state encodings.
//     - Init ROM length (6).
//   Sub-module lcd_byte_sender:
//     - Inputs: start, byte, rs, long_wait.
//     - Outputs: busy, EN/RS/DATA.
//     - Owns the SETUP/PULSE/HOLD timing and the wait counter.
//   Top-level (this module): PWRUP, init ROM indexing, request latch, byte iteration, zero-skip.
// TESTING (sim parameters: EN_PULSE_CYC=2, CMD_WAIT_CYC=5, CLR_WAIT_CYC=20, PWRUP_WAIT_CYC=50)
//   1. Reset release, no requests -> no EN before cycle 50; then EN pulses carry 38,38,38,0C,01,06 with RS=0;
//      gap after 01 >= 20 clks; LCD_Available=1 after the last wait.
//   2. data=" UIU", selectCD=1, enableWriting 1-clk pulse -> Available=0 next clk;
//      EN pulses with DATA 20,55,49,55, RS=1, EN high exactly 2 clks each; then Available=1.
//   3. data=32'h0000_4100, selectCD=1 -> exactly one EN pulse, DATA=41; zeros skipped.
//   4. selectCD=0, data[7:0]=01 -> one pulse with RS=0, DATA=01; Available returns after >= 20-clk wait.
//      Repeat with C0 -> 5-clk wait.
//   5. enableWriting held high for 200 clks with " UIU" -> back-to-back 4-byte transactions;
//      requests never accepted while Available=0; data changed mid-transaction does not alter bytes in flight.
//   6. Assert rst during PULSE of byte 2 -> EN=0 asynchronously, Available=0; after release, full PWRUP+INIT repeats.
//      Throughout: LCD_RW=0, LCD_ON=1, LCD_BLON=1.

Source files
------------

// File: rtl/lcd_char_writer_pkg.sv
// Shared definitions for the HD44780 write-side controller: command bytes,
// state encodings and the power-up init ROM.
package lcd_char_writer_pkg;

  localparam logic [7:0] CMD_FUNCSET_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] CMD_SET_DDRAM    = 8'h80;

  localparam int INIT_LEN = 6;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_NEXT
  } top_state_e;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_SETUP,
    BS_PULSE,
    BS_HOLD
  } sender_state_e;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = CMD_FUNCSET_8B2L;
      3'd3:             init_byte = CMD_DISP_ON;
      3'd4:             init_byte = CMD_CLEAR;
      default:          init_byte = CMD_ENTRY_INC;
    endcase
  endfunction

  // Character slot 0 is the most significant byte, i.e. the first one on the bus.
  function automatic logic [7:0] char_at(input logic [31:0] word, input logic [1:0] slot);
    case (slot)
      2'd0:    char_at = word[31:24];
      2'd1:    char_at = word[23:16];
      2'd2:    char_at = word[15:8];
      default: char_at = word[7:0];
    endcase
  endfunction

  function automatic logic needs_long_wait(input logic rs, input logic [7:0] b);
    return !rs && (b == CMD_CLEAR || b == CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_byte_sender.sv
// Drives one byte onto the LCD bus: a setup clock, an EN pulse, then a hold
// period with EN low whose length depends on whether the byte is clear/home.
module lcd_byte_sender
  import lcd_char_writer_pkg::*;
#(
  parameter int EN_PULSE_CYC = 14,
  parameter int CMD_WAIT_CYC = 1080,
  parameter int CLR_WAIT_CYC = 44280,
  parameter int CNT_W        = 19
) (
  input  logic       CLOCK_27,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       rs,
  input  logic       long_wait,
  output logic       busy,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

  sender_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] wait_last;

  assign wait_last = long_q ? CLR_LAST : CMD_LAST;

  always_comb begin
    // NOTE: every _d takes its held value first, so no branch can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    case (state_q)
      BS_IDLE: begin
        if (start) begin
          data_d  = tx_byte;
          rs_d    = rs;
          long_d  = long_wait;
          state_d = BS_SETUP;
        end
      end
      BS_SETUP: begin
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = BS_PULSE;
      end
      BS_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = BS_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BS_HOLD: begin
        if (cnt_q == wait_last) begin
          cnt_d   = '0;
          state_d = BS_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = BS_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; the async
  // reset drops EN and clears the bus the instant rst rises.
  always_ff @(posedge CLOCK_27 or posedge rst) begin
    if (rst) begin
      state_q <= BS_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  assign busy     = (state_q != BS_IDLE);
  assign lcd_en   = en_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 write controller for the DE2 16x2 LCD: power-up wait, init sequence,
// then one request (4 packed chars or one command) per enableWriting handshake.
module lcd_char_writer
  import lcd_char_writer_pkg::*;
#(
  parameter int EN_PULSE_CYC   = 14,
  parameter int CMD_WAIT_CYC   = 1080,
  parameter int CLR_WAIT_CYC   = 44280,
  parameter int PWRUP_WAIT_CYC = 405000
) (
  input  logic        CLOCK_27,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        selectCD,
  input  logic        enableWriting,
  output logic        LCD_Available,
  inout  wire  [7:0]  LCD_DATA,
  output logic        LCD_RW,
  output logic        LCD_RS,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        LCD_BLON
);

  localparam int               CNT_W      = $clog2(PWRUP_WAIT_CYC + 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_WAIT_CYC - 1);
  localparam logic [2:0]       INIT_LAST  = 3'(INIT_LEN - 1);
  localparam logic [2:0]       SLOT_LAST  = 3'd3;

  top_state_e       state_q, state_d;
  logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      req_data_q, req_data_d;
  logic             req_cd_q, req_cd_d;
  logic             avail_q, avail_d;
  logic             init_q, init_d;

  logic       found;
  logic [2:0] found_idx;
  logic       start;
  logic [7:0] send_byte;
  logic       send_rs;
  logic       busy;
  logic [7:0] bus_data;

  // Next slot to send: commands always go out; characters skip 8'h00.
  always_comb begin
    found     = 1'b0;
    found_idx = idx_q;
    if (!req_cd_q) begin
      found = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!found && i >= int'(idx_q) && char_at(req_data_q, 2'(i)) != 8'h00) begin
          found     = 1'b1;
          found_idx = 3'(i);
        end
      end
    end
  end

  assign send_byte = (state_q == ST_INIT) ? init_byte(idx_q) : char_at(req_data_q, found_idx[1:0]);
  assign send_rs   = (state_q == ST_INIT) ? 1'b0 : req_cd_q;
  assign start     = (state_q == ST_INIT) || (state_q == ST_LOAD && found);

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    idx_d      = idx_q;
    req_data_d = req_data_q;
    req_cd_d   = req_cd_q;
    avail_d    = avail_q;
    init_d     = init_q;
    case (state_q)
      ST_PWRUP: begin
        if (pwr_cnt_q == PWRUP_LAST) begin
          idx_d   = 3'd0;
          state_d = ST_INIT;
        end else begin
          pwr_cnt_d = pwr_cnt_q + CNT_W'(1);
        end
      end
      ST_INIT: state_d = ST_SEND;
      ST_IDLE: begin
        if (enableWriting) begin
          req_data_d = data;
          req_cd_d   = selectCD;
          // A command is the last slot, so it finishes after one byte.
          idx_d      = selectCD ? 3'd0 : SLOT_LAST;
          avail_d    = 1'b0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (found) begin
          idx_d   = found_idx;
          state_d = ST_SEND;
        end else begin
          idx_d   = SLOT_LAST;
          state_d = ST_NEXT;
        end
      end
      ST_SEND: begin
        if (!busy) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (init_q) begin
          if (idx_q == INIT_LAST) begin
            init_d  = 1'b0;
            avail_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_INIT;
          end
        end else if (idx_q == SLOT_LAST) begin
          avail_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  always_ff @(posedge CLOCK_27 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PWRUP;
      pwr_cnt_q  <= '0;
      idx_q      <= 3'd0;
      req_data_q <= 32'h0;
      req_cd_q   <= 1'b0;
      avail_q    <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      idx_q      <= idx_d;
      req_data_q <= req_data_d;
      req_cd_q   <= req_cd_d;
      avail_q    <= avail_d;
      init_q     <= init_d;
    end
  end

  lcd_byte_sender #(
    .EN_PULSE_CYC (EN_PULSE_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC),
    .CNT_W        (CNT_W)
  ) u_sender (
    .CLOCK_27  (CLOCK_27),
    .rst       (rst),
    .start     (start),
    .tx_byte   (send_byte),
    .rs        (send_rs),
    .long_wait (needs_long_wait(send_rs, send_byte)),
    .busy      (busy),
    .lcd_en    (LCD_EN),
    .lcd_rs    (LCD_RS),
    .lcd_data  (bus_data)
  );

  assign LCD_DATA      = bus_data;
  assign LCD_Available = avail_q;
  assign LCD_RW        = 1'b0;
  assign LCD_ON        = 1'b1;
  assign LCD_BLON      = 1'b1;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Randomized bench for lcd_char_writer: a bus monitor checks every EN pulse
// against a byte-level model of what each accepted request should produce.
module tb_lcd_char_writer;

  localparam int EN_P  = 2;
  localparam int CMD_W = 5;
  localparam int CLR_W = 20;
  localparam int PWR_W = 50;
  localparam logic [31:0] UIU = 32'h2055_4955;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'h0;
  logic        cd = 1'b0;
  logic        en_wr = 1'b0;
  wire  [7:0]  lcd_data;
  logic        avail, lcd_rw, lcd_rs, lcd_en, lcd_on, lcd_blon;

  lcd_char_writer #(
    .EN_PULSE_CYC   (EN_P),
    .CMD_WAIT_CYC   (CMD_W),
    .CLR_WAIT_CYC   (CLR_W),
    .PWRUP_WAIT_CYC (PWR_W)
  ) dut (
    .CLOCK_27      (clk),
    .rst           (rst),
    .data          (data),
    .selectCD      (cd),
    .enableWriting (en_wr),
    .LCD_Available (avail),
    .LCD_DATA      (lcd_data),
    .LCD_RW        (lcd_rw),
    .LCD_RS        (lcd_rs),
    .LCD_EN        (lcd_en),
    .LCD_ON        (lcd_on),
    .LCD_BLON      (lcd_blon)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rs;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rel_cyc = 0;
  int   n_acc = 0;
  int   n_rise = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: a command is one RS=0 byte; characters go MSB first, zeros dropped.
  function automatic void push_request(input logic [31:0] d, input logic c);
    if (!c) begin
      exp_q.push_back('{rs: 1'b0, b: d[7:0]});
    end else begin
      for (int k = 3; k >= 0; k--)
        if (d[8*k +: 8] != 8'h00) exp_q.push_back('{rs: 1'b1, b: d[8*k +: 8]});
    end
  endfunction

  function automatic void push_init();
    logic [7:0] seq [6];
    seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int k = 0; k < 6; k++) exp_q.push_back('{rs: 1'b0, b: seq[k]});
  endfunction

  logic prev_en = 1'b0;
  logic prev_avail = 1'b0;
  logic first_en = 1'b1;
  logic have_fall = 1'b0;
  int   hi_cnt = 0;
  int   fall_cyc = 0;
  int   wait_req = 0;
  exp_t cur;

  // Bus monitor and request acceptor share one process so their order is fixed.
  always @(negedge clk) begin
    if (rst) begin
      prev_en    = 1'b0;
      prev_avail = 1'b0;
      first_en   = 1'b1;
      have_fall  = 1'b0;
      hi_cnt     = 0;
    end else begin
      if (lcd_en && !prev_en) begin
        n_rise++;
        check("const_outs", 32'({lcd_rw, lcd_on, lcd_blon}), 32'h3);
        if (first_en) begin
          check("pwrup_gap", 32'(cyc - rel_cyc >= PWR_W), 1);
          first_en = 1'b0;
        end
        if (have_fall) check("post_wait", 32'(cyc - fall_cyc >= wait_req), 1);
        check("en_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("bus_byte", 32'({lcd_rs, lcd_data}), 32'({cur.rs, cur.b}));
        end
        wait_req = (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02)) ? CLR_W : CMD_W;
        hi_cnt = 0;
      end
      if (lcd_en) hi_cnt++;
      if (!lcd_en && prev_en) begin
        check("en_width", 32'(hi_cnt), 32'(EN_P));
        fall_cyc  = cyc;
        have_fall = 1'b1;
      end
      if (avail && !prev_avail) begin
        if (have_fall) check("avail_wait", 32'(cyc - fall_cyc >= wait_req), 1);
        check("idle_q_empty", 32'(exp_q.size()), 0);
      end
      if (avail && en_wr) begin
        push_request(data, cd);
        n_acc++;
      end
      prev_en    = lcd_en;
      prev_avail = avail;
    end
  end

  task automatic wait_avail(input int budget, input string tag);
    int n;
    n = 0;
    while (avail !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(avail), 1);
  endtask

  task automatic do_req(input logic [31:0] d, input logic c);
    logic has_bytes;
    has_bytes = !c || (d != 32'h0);
    wait_avail(4000, "req_ready");
    @(posedge clk); #1;
    data  = d;
    cd    = c;
    en_wr = 1'b1;
    @(posedge clk); #1;
    en_wr = 1'b0;
    check("acc_avail_drop", 32'(avail), 0);
    data = $urandom;
    cd   = 1'($urandom);
    @(posedge clk); #1;
    if (has_bytes) check("setup_en_low", 32'(lcd_en), 0);
    else           check("zero_busy", 32'(avail), 0);
    @(posedge clk); #1;
    if (has_bytes) check("first_en_rise", 32'(lcd_en), 1);
    else           check("zero_idle", 32'(avail), 1);
    wait_avail(4000, "req_done");
  endtask

  initial begin
    logic [31:0] d;
    logic        c;
    int          acc0;
    int          r0;
    int          n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_avail", 32'(avail), 0);
    check("rst_en", 32'(lcd_en), 0);
    check("rst_rs_bus", 32'({lcd_rs, lcd_data}), 0);
    check("rst_const", 32'({lcd_rw, lcd_on, lcd_blon}), 32'h3);
    rst     = 1'b0;
    rel_cyc = cyc;
    push_init();
    wait_avail(3000, "init_done");
    check("init_q_empty", 32'(exp_q.size()), 0);

    do_req(UIU, 1'b1);
    do_req(32'h0000_4100, 1'b1);
    do_req(32'h0000_0001, 1'b0);
    do_req(32'hABCD_12C0, 1'b0);
    do_req(32'h0000_0000, 1'b1);

    for (int k = 0; k < 20; k++) begin
      d = $urandom;
      for (int j = 0; j < 4; j++)
        if ($urandom_range(3) == 0) d[8*j +: 8] = 8'h00;
      c = 1'($urandom_range(1));
      if (!c && $urandom_range(2) == 0) d[7:0] = ($urandom_range(1) == 1) ? 8'h01 : 8'h02;
      do_req(d, c);
    end

    // Level-held request: back-to-back transactions, data disturbed mid-flight.
    wait_avail(4000, "b2b_ready");
    @(posedge clk); #1;
    data  = UIU;
    cd    = 1'b1;
    en_wr = 1'b1;
    acc0  = n_acc;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (k % 9 == 4) data = (k % 18 == 4) ? $urandom : UIU;
    end
    en_wr = 1'b0;
    wait_avail(4000, "b2b_done");
    check("b2b_accepts", 32'(n_acc - acc0 >= 3), 1);

    // Reset in the middle of the second EN pulse.
    wait_avail(4000, "rst_req_ready");
    @(posedge clk); #1;
    data  = UIU;
    cd    = 1'b1;
    en_wr = 1'b1;
    @(posedge clk); #1;
    en_wr = 1'b0;
    r0 = n_rise;
    n  = 0;
    while (n_rise < r0 + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_byte2", 32'(n_rise >= r0 + 2), 1);
    #2;
    check("pre_rst_en", 32'(lcd_en), 1);
    rst = 1'b1;
    #1;
    check("rst_en_async", 32'(lcd_en), 0);
    check("rst_avail_async", 32'(avail), 0);
    check("rst_bus_async", 32'({lcd_rs, lcd_data}), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    rel_cyc = cyc;
    push_init();
    wait_avail(3000, "reinit_done");
    check("reinit_q_empty", 32'(exp_q.size()), 0);
    do_req(32'h4F4B_0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
